// File: rtl/riscv_pkg.sv
// Shared decode constants, issue-order encoding and steering FSM states for the dual-issue front end.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ORD_A_B    = 2'b00,
        ORD_B_A    = 2'b01,
        ORD_A_ONLY = 2'b10,
        ORD_B_ONLY = 2'b11
    } order_e;

    typedef enum logic {
        ST_PAIR = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid_a;
        logic        valid_b;
        logic [31:0] instr_a;
        logic [31:0] instr_b;
        logic [31:0] pc_a;
        logic [31:0] pc_b;
        order_e      order;
    } issue_t;

    localparam issue_t ISSUE_IDLE = '0;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // A lone instruction goes to lane B only if it needs the memory port.
    function automatic issue_t issue_single(input logic [31:0] instr,
                                            input logic [31:0] pc,
                                            input logic        is_mem);
        issue_t r;
        r = ISSUE_IDLE;
        if (is_mem) begin
            r.valid_b = 1'b1;
            r.instr_b = instr;
            r.pc_b    = pc;
            r.order   = ORD_B_ONLY;
        end else begin
            r.valid_a = 1'b1;
            r.instr_a = instr;
            r.pc_a    = pc;
            r.order   = ORD_A_ONLY;
        end
        return r;
    endfunction

endpackage

// File: rtl/pair_hazard.sv
// Combinational pairing check for a fetch pair: memory/control/RAW flags and split/swap decision.
// ISSUE_SWAP_EN: when defined, a memory instr0 with a non-memory instr1 is swapped instead of split.
module pair_hazard
    import riscv_pkg::*;
(
    input  logic [31:0] instr0,
    input  logic [31:0] instr1,
    output logic        mem0,
    output logic        mem1,
    output logic        ctrl0,
    output logic        raw,
    output logic        split,
    output logic        swap
);

    logic [31:0] instr [2];
    logic [1:0]  is_mem;
    logic [1:0]  is_ctrl;
    logic [1:0]  rd_wr;
    logic [1:0]  rs1_rd;
    logic [1:0]  rs2_rd;
    logic [4:0]  rd  [2];
    logic [4:0]  rs1 [2];
    logic [4:0]  rs2 [2];

    assign instr[0] = instr0;
    assign instr[1] = instr1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [6:0] op;
            assign op          = instr[gi][6:0];
            assign rd[gi]      = instr[gi][11:7];
            assign rs1[gi]     = instr[gi][19:15];
            assign rs2[gi]     = instr[gi][24:20];
            assign is_mem[gi]  = is_mem_op(op);
            assign is_ctrl[gi] = (op == OP_BRANCH) || (op == OP_JAL);
            // Writes to x0 are architecturally discarded, so they never create a RAW.
            assign rd_wr[gi]   = ((op == OP_OP) || (op == OP_OP_IMM) || (op == OP_LOAD) || (op == OP_JAL))
                                 && (instr[gi][11:7] != 5'd0);
            assign rs1_rd[gi]  = (op == OP_OP) || (op == OP_OP_IMM) || (op == OP_LOAD)
                                 || (op == OP_STORE) || (op == OP_BRANCH);
            assign rs2_rd[gi]  = (op == OP_OP) || (op == OP_STORE) || (op == OP_BRANCH);
        end
    endgenerate

    assign mem0  = is_mem[0];
    assign mem1  = is_mem[1];
    assign ctrl0 = is_ctrl[0];
    assign raw   = rd_wr[0] && ((rs1_rd[1] && (rs1[1] == rd[0])) || (rs2_rd[1] && (rs2[1] == rd[0])));

`ifdef ISSUE_SWAP_EN
    assign split = raw || (mem0 && mem1) || ctrl0;
    assign swap  = !split && mem0 && !mem1;
`else
    // Without swapping, lane A can never take instr1 while instr0 holds lane B.
    assign split = raw || (mem0 && mem1) || ctrl0 || (mem0 && !mem1);
    assign swap  = 1'b0;
`endif

    logic unused_dec;
    assign unused_dec = ^{is_ctrl[1], rd_wr[1], rs1_rd[0], rs2_rd[0], rd[1], rs1[0], rs2[0],
                          instr0[31:25], instr0[14:12], instr1[31:25], instr1[14:12]};

endmodule

// File: rtl/dual_issue_steer.sv
// Steers a fetched instruction pair onto lanes A/B (memory only in B), splitting via a one-entry hold buffer.
// ISSUE_SWAP_EN (see pair_hazard) selects swap-vs-split for a memory instr0 followed by a non-memory instr1.
module dual_issue_steer
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr0_F,
    input  logic [31:0] instr1_F,
    input  logic [31:0] pc_F,
    input  logic        valid_F,
    output logic        ready_F,
    input  logic        stall_D,
    input  logic        flush_D,
    output logic [31:0] instrA_D,
    output logic [31:0] instrB_D,
    output logic [31:0] pcA_D,
    output logic [31:0] pcB_D,
    output logic        validA_D,
    output logic        validB_D,
    output logic [1:0]  order_D
);

    state_e      state_reg, state_next;
    issue_t      out_reg, out_next;
    logic [31:0] hold_instr_reg, hold_instr_next;
    logic [31:0] hold_pc_reg, hold_pc_next;
    logic        hold_mem_reg, hold_mem_next;

    logic mem0, mem1, ctrl0, raw, split, swap;
    logic accept;

    pair_hazard u_pair_hazard (
        .instr0 (instr0_F),
        .instr1 (instr1_F),
        .mem0   (mem0),
        .mem1   (mem1),
        .ctrl0  (ctrl0),
        .raw    (raw),
        .split  (split),
        .swap   (swap)
    );

    always_comb begin
        state_next      = state_reg;
        out_next        = out_reg;
        hold_instr_next = hold_instr_reg;
        hold_pc_next    = hold_pc_reg;
        hold_mem_next   = hold_mem_reg;
        ready_F         = reset_n && (state_reg == ST_PAIR) && !stall_D && !flush_D;
        accept          = valid_F && ready_F;

        if (flush_D) begin
            out_next        = ISSUE_IDLE;
            hold_instr_next = '0;
            hold_pc_next    = '0;
            hold_mem_next   = 1'b0;
            state_next      = ST_PAIR;
        end else if (!stall_D) begin
            if (state_reg == ST_HOLD) begin
                out_next        = issue_single(hold_instr_reg, hold_pc_reg, hold_mem_reg);
                hold_instr_next = '0;
                hold_pc_next    = '0;
                hold_mem_next   = 1'b0;
                state_next      = ST_PAIR;
            end else if (accept) begin
                if (split) begin
                    out_next        = issue_single(instr0_F, pc_F, mem0);
                    hold_instr_next = instr1_F;
                    hold_pc_next    = pc_F + 32'd4;
                    hold_mem_next   = mem1;
                    state_next      = ST_HOLD;
                end else if (swap) begin
                    out_next = '{valid_a: 1'b1, valid_b: 1'b1,
                                 instr_a: instr1_F, instr_b: instr0_F,
                                 pc_a: pc_F + 32'd4, pc_b: pc_F, order: ORD_B_A};
                end else begin
                    out_next = '{valid_a: 1'b1, valid_b: 1'b1,
                                 instr_a: instr0_F, instr_b: instr1_F,
                                 pc_a: pc_F, pc_b: pc_F + 32'd4, order: ORD_A_B};
                end
            end else begin
                out_next = ISSUE_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_PAIR;
            out_reg        <= ISSUE_IDLE;
            hold_instr_reg <= '0;
            hold_pc_reg    <= '0;
            hold_mem_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            out_reg        <= out_next;
            hold_instr_reg <= hold_instr_next;
            hold_pc_reg    <= hold_pc_next;
            hold_mem_reg   <= hold_mem_next;
        end
    end

    assign instrA_D = out_reg.instr_a;
    assign instrB_D = out_reg.instr_b;
    assign pcA_D    = out_reg.pc_a;
    assign pcB_D    = out_reg.pc_b;
    assign validA_D = out_reg.valid_a;
    assign validB_D = out_reg.valid_b;
    assign order_D  = out_reg.order;

    // Control and RAW only matter through the split decision.
    logic unused_flags;
    assign unused_flags = ctrl0 ^ raw;

endmodule

// File: tb/tb_dual_issue_steer.sv
// Bench for dual_issue_steer: bundle-queue reference model checked every cycle, plus directed literal checks.
module tb_dual_issue_steer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr0_F, instr1_F, pc_F;
    logic        valid_F, ready_F, stall_D, flush_D;
    logic [31:0] instrA_D, instrB_D, pcA_D, pcB_D;
    logic        validA_D, validB_D;
    logic [1:0]  order_D;

    int checks   = 0;
    int failures = 0;

`ifdef ISSUE_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    dual_issue_steer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .instr0_F (instr0_F),
        .instr1_F (instr1_F),
        .pc_F     (pc_F),
        .valid_F  (valid_F),
        .ready_F  (ready_F),
        .stall_D  (stall_D),
        .flush_D  (flush_D),
        .instrA_D (instrA_D),
        .instrB_D (instrB_D),
        .pcA_D    (pcA_D),
        .pcB_D    (pcB_D),
        .validA_D (validA_D),
        .validB_D (validB_D),
        .order_D  (order_D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a queue of pending issue bundles ----------------
    typedef struct {
        logic        va, vb;
        logic [31:0] ia, ib, pa, pb;
        logic [1:0]  ord;
    } bund_t;

    bund_t exp_b;
    bund_t pend[$];
    bit    chk_en = 1'b0;

    function automatic bund_t idle_b();
        bund_t b;
        b.va = 0; b.vb = 0; b.ia = 0; b.ib = 0; b.pa = 0; b.pb = 0; b.ord = 2'b00;
        return b;
    endfunction

    function automatic bit m_mem(input logic [31:0] i);
        return i[6:0] == 7'h03 || i[6:0] == 7'h23;
    endfunction
    function automatic bit m_ctrl(input logic [31:0] i);
        return i[6:0] == 7'h63 || i[6:0] == 7'h6F;
    endfunction
    function automatic bit m_writes(input logic [31:0] i);
        return (i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h6F}) && i[11:7] != 0;
    endfunction
    function automatic bit m_reads(input logic [31:0] i, input logic [4:0] r);
        bit r1, r2;
        r1 = i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        r2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
        return (r1 && i[19:15] == r) || (r2 && i[24:20] == r);
    endfunction

    function automatic bund_t solo(input logic [31:0] i, input logic [31:0] pc);
        bund_t b;
        b = idle_b();
        if (m_mem(i)) begin b.vb = 1; b.ib = i; b.pb = pc; b.ord = 2'b11; end
        else          begin b.va = 1; b.ia = i; b.pa = pc; b.ord = 2'b10; end
        return b;
    endfunction

    task automatic model_accept(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        bit brk;
        brk = (m_writes(i0) && m_reads(i1, i0[11:7])) || (m_mem(i0) && m_mem(i1)) || m_ctrl(i0)
              || (m_mem(i0) && !m_mem(i1) && !SWAP_EN);
        exp_b = idle_b();
        if (brk) begin
            exp_b = solo(i0, pc);
            pend.push_back(solo(i1, pc + 4));
        end else begin
            exp_b.va = 1; exp_b.vb = 1;
            if (m_mem(i0)) begin
                exp_b.ia = i1; exp_b.pa = pc + 4; exp_b.ib = i0; exp_b.pb = pc; exp_b.ord = 2'b01;
            end else begin
                exp_b.ia = i0; exp_b.pa = pc; exp_b.ib = i1; exp_b.pb = pc + 4; exp_b.ord = 2'b00;
            end
        end
    endtask

    initial exp_b = idle_b();

    always @(posedge clk) begin
        if (!reset_n) begin
            exp_b = idle_b();
            pend.delete();
        end else if (flush_D) begin
            exp_b = idle_b();
            pend.delete();
        end else if (!stall_D) begin
            if (pend.size() != 0) exp_b = pend.pop_front();
            else if (valid_F)     model_accept(instr0_F, instr1_F, pc_F);
            else                  exp_b = idle_b();
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", {31'd0, ready_F}, {31'd0, reset_n && pend.size() == 0 && !stall_D && !flush_D});
            chk("m_validA", {31'd0, validA_D}, {31'd0, exp_b.va});
            chk("m_validB", {31'd0, validB_D}, {31'd0, exp_b.vb});
            chk("m_instrA", instrA_D, exp_b.ia);
            chk("m_instrB", instrB_D, exp_b.ib);
            chk("m_pcA", pcA_D, exp_b.pa);
            chk("m_pcB", pcB_D, exp_b.pb);
            chk("m_order", {30'd0, order_D}, {30'd0, exp_b.ord});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
        instr0_F = i0; instr1_F = i1; pc_F = pc; valid_F = 1'b1;
    endtask

    task automatic expect_out(input string n, input logic va, input logic [31:0] ia, input logic [31:0] pa,
                              input logic vb, input logic [31:0] ib, input logic [31:0] pb,
                              input logic [1:0] ord);
        $display("txn %s: A=%0b/%h@%h B=%0b/%h@%h ord=%b ready=%0b", n,
                 validA_D, instrA_D, pcA_D, validB_D, instrB_D, pcB_D, order_D, ready_F);
        chk({n, "_vA"}, {31'd0, validA_D}, {31'd0, va});
        chk({n, "_iA"}, instrA_D, ia);
        chk({n, "_pA"}, pcA_D, pa);
        chk({n, "_vB"}, {31'd0, validB_D}, {31'd0, vb});
        chk({n, "_iB"}, instrB_D, ib);
        chk({n, "_pB"}, pcB_D, pb);
        chk({n, "_ord"}, {30'd0, order_D}, {30'd0, ord});
    endtask

    task automatic expect_ready(input string n, input logic r);
        chk({n, "_ready"}, {31'd0, ready_F}, {31'd0, r});
    endtask

    localparam logic [31:0] ADD1  = 32'h003100B3;  // add x1,x2,x3
    localparam logic [31:0] ADD4  = 32'h00628233;  // add x4,x5,x6
    localparam logic [31:0] ADDI4 = 32'h00108213;  // addi x4,x1,1
    localparam logic [31:0] LW5   = 32'h00012283;  // lw x5,0(x2)
    localparam logic [31:0] ADD6  = 32'h00838333;  // add x6,x7,x8
    localparam logic [31:0] SW6   = 32'h0063A023;  // sw x6,0(x7)
    localparam logic [31:0] BEQ   = 32'h00000063;  // beq x0,x0,0
    localparam logic [31:0] ADDI0 = 32'h00108013;  // addi x0,x1,1
    localparam logic [31:0] ADD40 = 32'h00000233;  // add x4,x0,x0
    localparam logic [31:0] JAL1  = 32'h008000EF;  // jal x1,8

    logic [31:0] tbl [10];
    logic [31:0] rnd;

    initial begin
        tbl = '{ADD1, ADD4, ADDI4, LW5, ADD6, SW6, BEQ, ADDI0, ADD40, JAL1};
        reset_n = 1'b0; instr0_F = '0; instr1_F = '0; pc_F = '0;
        valid_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
        repeat (3) tick();
        expect_out("reset", 0, 0, 0, 0, 0, 0, 2'b00);
        expect_ready("reset", 1'b0);
        reset_n = 1'b1;
        #1 expect_ready("release", 1'b1);

        // independent ALU pair
        drive_pair(ADD1, ADD4, 32'h100);
        tick(); valid_F = 1'b0;
        expect_out("alu_pair", 1, ADD1, 32'h100, 1, ADD4, 32'h104, 2'b00);
        expect_ready("alu_pair", 1'b1);
        tick();

        // RAW split
        drive_pair(ADD1, ADDI4, 32'h100);
        tick(); valid_F = 1'b0;
        expect_out("raw_c1", 1, ADD1, 32'h100, 0, 0, 0, 2'b10);
        expect_ready("raw_c1", 1'b0);
        tick();
        expect_out("raw_c2", 1, ADDI4, 32'h104, 0, 0, 0, 2'b10);
        expect_ready("raw_c3", 1'b1);
        tick();
        expect_out("raw_idle", 0, 0, 0, 0, 0, 0, 2'b00);

        // load followed by ALU op
        drive_pair(LW5, ADD6, 32'h300);
        tick(); valid_F = 1'b0;
        if (SWAP_EN) begin
            expect_out("swap", 1, ADD6, 32'h304, 1, LW5, 32'h300, 2'b01);
            tick();
        end else begin
            expect_out("noswap_c1", 0, 0, 0, 1, LW5, 32'h300, 2'b11);
            tick();
            expect_out("noswap_c2", 1, ADD6, 32'h304, 0, 0, 0, 2'b10);
            tick();
        end

        // two memory ops
        drive_pair(LW5, SW6, 32'h400);
        tick(); valid_F = 1'b0;
        expect_out("mem2_c1", 0, 0, 0, 1, LW5, 32'h400, 2'b11);
        tick();
        expect_out("mem2_c2", 0, 0, 0, 1, SW6, 32'h404, 2'b11);
        tick();

        // branch in slot 0 splits; x0 destination never causes RAW
        drive_pair(BEQ, ADD1, 32'h800);
        tick(); valid_F = 1'b0;
        expect_out("ctrl_c1", 1, BEQ, 32'h800, 0, 0, 0, 2'b10);
        tick();
        expect_out("ctrl_c2", 1, ADD1, 32'h804, 0, 0, 0, 2'b10);
        drive_pair(ADDI0, ADD40, 32'h900);
        tick(); valid_F = 1'b0;
        expect_out("x0_pair", 1, ADDI0, 32'h900, 1, ADD40, 32'h904, 2'b00);
        tick();

        // stall while holding, then flush
        drive_pair(ADD1, ADDI4, 32'h500);
        tick(); valid_F = 1'b0; stall_D = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out("stall_hold", 1, ADD1, 32'h500, 0, 0, 0, 2'b10);
            expect_ready("stall_hold", 1'b0);
        end
        flush_D = 1'b1;
        tick(); flush_D = 1'b0; stall_D = 1'b0;
        expect_out("flush", 0, 0, 0, 0, 0, 0, 2'b00);
        #1 expect_ready("flush_pair", 1'b1);
        tick();
        expect_out("flush_dropped", 0, 0, 0, 0, 0, 0, 2'b00);

        // reset while holding
        drive_pair(ADD1, ADDI4, 32'h600);
        tick(); valid_F = 1'b0; reset_n = 1'b0;
        tick();
        expect_out("rst_hold", 0, 0, 0, 0, 0, 0, 2'b00);
        expect_ready("rst_hold", 1'b0);
        reset_n = 1'b1;
        drive_pair(ADD1, ADD4, 32'h700);
        tick(); valid_F = 1'b0;
        expect_out("rst_after", 1, ADD1, 32'h700, 1, ADD4, 32'h704, 2'b00);

        // mixed traffic checked by the per-cycle model only
        for (int c = 0; c < 400; c++) begin
            instr0_F = tbl[$urandom_range(0, 9)];
            instr1_F = tbl[$urandom_range(0, 9)];
            rnd      = $urandom;
            pc_F     = rnd & 32'hFFFF_FFF8;
            valid_F  = ($urandom_range(0, 3) != 0);
            stall_D  = ($urandom_range(0, 6) == 0);
            flush_D  = ($urandom_range(0, 30) == 0);
            reset_n  = ($urandom_range(0, 80) != 0);
            tick();
        end
        valid_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0; reset_n = 1'b1;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_issue_steer.md
DUAL_ISSUE_STEER -- requirements
Module: dual_issue_steer

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset_n`, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port `instr0_F`, input, 32 bits: the older fetched instruction, at address `pc_F`.
REQ-004 SHALL have port `instr1_F`, input, 32 bits: the younger fetched instruction, at address `pc_F`+4.
REQ-005 SHALL have port `pc_F`, input, 32 bits: fetch-pair base address.
REQ-006 SHALL have port `valid_F`, input, 1 bit: the fetch pair is present.
REQ-007 SHALL have port `ready_F`, output, 1 bit: the block accepts the pair this cycle.
REQ-008 SHALL have port `stall_D`, input, 1 bit: decode cannot take new outputs.
REQ-009 SHALL have port `flush_D`, input, 1 bit: kill all in-flight and held instructions.
REQ-010 SHALL have ports `instrA_D` and `instrB_D`, outputs, 32 bits each: instruction steered to lane A and lane B.
REQ-011 SHALL have ports `pcA_D` and `pcB_D`, outputs, 32 bits each: the lane PCs.
REQ-012 SHALL have ports `validA_D` and `validB_D`, outputs, 1 bit each: lane occupied.
REQ-013 SHALL have port `order_D`, output, 2 bits: 00 = A older than B; 01 = B older than A; 10 = A only; 11 = B only.

Function
REQ-014 SHALL register all D outputs, with 1-cycle latency from accept (`valid_F` && `ready_F`) to appearance on D.
REQ-015 SHALL classify an instruction as memory if opcode is 0000011 or 0100011; as control if opcode is 1100011 or 1101111.
REQ-016 SHALL treat a register as read via rs1 for R/I/load/store/branch, and via rs2 for R/store/branch.
REQ-017 SHALL treat rd as written for R/I/load/jal, excluding rd = x0.
REQ-018 SHALL never place a memory instruction in lane A; only lane B has memory access.
REQ-019 SHALL split the pair under any of these conditions: instr1 reads instr0's rd (RAW); both instructions are memory; instr0 is control.
REQ-020 SHALL pair the instructions otherwise: if instr1 is memory, put instr0 in A and instr1 in B with `order_D`=00; if instr0 is memory, swap them with `order_D`=01; if neither is memory, use A=instr0, B=instr1, `order_D`=00.
REQ-021 SHALL, on a split, issue instr0 alone (lane B if memory with `order_D`=11, else lane A with `order_D`=10), latch instr1 and `pc_F`+4 into the hold buffer, and enter state HOLD.
REQ-022 SHALL use a two-state FSM. PAIR: `ready_F`=1. HOLD: `ready_F`=0; issue the held instruction alone, steered per REQ-021, then go to PAIR.
REQ-023 SHALL, while `stall_D`=1, hold outputs, FSM state and buffer unchanged and drive `ready_F`=0.
REQ-024 SHALL, on `flush_D`=1 (priority over `stall_D` and `valid_F`), clear both valid outputs next cycle, discard the buffer and go to PAIR.
REQ-025 SHALL, when no pair is accepted and not in HOLD and not stalled, load both valid outputs to 0.
REQ-026 SHALL drive the instruction and PC fields of an invalid lane to 0.

Reset
REQ-027 SHALL, while `reset_n`=0 at a clock edge, load state PAIR, clear the buffer, and drive every D output to 0 (`order_D`=00). Reset during HOLD discards the held instruction.
REQ-028 SHALL drive `ready_F`=0 during reset and `ready_F`=1 in the first cycle after release.

Configuration
REQ-029 SHALL, with macro `ISSUE_SWAP_EN` defined, swap per REQ-020 when instr0 is memory and instr1 is not.
REQ-030 SHALL, without `ISSUE_SWAP_EN`, split that case instead: instr0 issues alone in lane B, then instr1 issues alone in lane A; ordering is never 01.

Structure
REQ-031 SHALL take opcode constants, the `order_D` encoding enum and the FSM state enum from shared package `riscv_pkg`.
REQ-032 SHALL contain one combinational sub-module `pair_hazard` computing the memory, control and RAW flags and the split/swap decision.

Verification
REQ-033 SHALL cover: 0x003100B3 + 0x00628233, `pc_F`=0x100 -> next cycle A=0x003100B3 @0x100, B=0x00628233 @0x104, `order_D`=00, `ready_F` stays 1.
REQ-034 SHALL cover: 0x003100B3 + 0x00108213 -> cycle 1 A-only 0x003100B3, `order_D`=10, `ready_F`=0; cycle 2 A-only 0x00108213 @0x104; cycle 3 `ready_F`=1.
REQ-035 SHALL cover: 0x00012283 (lw) + 0x00838333 -> with `ISSUE_SWAP_EN`: B=lw, A=add, `order_D`=01; without: lw B-only with `order_D`=11, then add A-only with `order_D`=10.
REQ-036 SHALL cover: lw + sw pair -> split, each lane B-only, `order_D`=11 twice.
REQ-037 SHALL cover: `stall_D` held 3 cycles in HOLD -> outputs and `ready_F`=0 frozen; then `flush_D` -> both valids 0, state PAIR, held instruction never issued.
REQ-038 SHALL cover: `reset_n`=0 mid-HOLD -> all outputs 0, and the next accepted pair issues normally.
